// File: rtl/tetris_pkg.sv
// Shared game constants: block row width, game FSM state codes, default
// keycodes, and the hold FSM state type used by hold_bank.
package tetris_pkg;

  localparam int unsigned BLOCK_W = 10;

  localparam logic [2:0] GS_SPAWN = 3'b010;
  localparam logic [2:0] GS_FALL  = 3'b100;

  localparam logic [7:0] HOLD_KEY_DEF  = 8'h06;
  localparam logic [7:0] CYCLE_KEY_DEF = 8'h07;

  typedef enum logic {
    HOLD_ARMED = 1'b0,
    HOLD_USED  = 1'b1
  } hold_state_t;

endpackage

// File: rtl/key_edge.sv
// Press-edge detector for one keycode.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   keycode    : current scancode (8'h00 = no key)
//   press      : high in the cycle keycode first equals KEY
module key_edge #(
  parameter logic [7:0] KEY = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] keycode,
  output logic       press
);

  logic [7:0] prev_key;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_key <= '0;
    else       prev_key <= keycode;
  end

  assign press = (keycode == KEY) && (prev_key != keycode);

endmodule

// File: rtl/hold_bank.sv
// Multi-slot hold bank for the falling piece.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   keycode    : current scancode; HOLD_KEY swaps, CYCLE_KEY selects slot
//   game_state : game FSM state (SPAWN re-arms, FALL permits a hold)
//   in_block   : active falling piece pattern
//   slot_sel   : selected slot index
//   sblock     : contents of selected slot
//   slot_full  : per-slot occupied flags
//   can_swap   : a hold is still permitted in this drop
//   swap_empty : no slot occupied
//   out_block  : piece returned by the last swap
//   swap_done  : one-cycle pulse, a held piece was returned
//   need_new   : one-cycle pulse, piece went into an empty slot
module hold_bank #(
  parameter int unsigned BLOCK_W   = tetris_pkg::BLOCK_W,
  parameter int unsigned ROWS      = 2,
  parameter int unsigned NUM_SLOTS = 4,
  parameter logic [7:0]  HOLD_KEY  = tetris_pkg::HOLD_KEY_DEF,
  parameter logic [7:0]  CYCLE_KEY = tetris_pkg::CYCLE_KEY_DEF
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [7:0]                          keycode,
  input  logic [2:0]                          game_state,
  input  logic [ROWS-1:0][BLOCK_W-1:0]        in_block,
  output logic [$clog2(NUM_SLOTS)-1:0]        slot_sel,
  output logic [ROWS-1:0][BLOCK_W-1:0]        sblock,
  output logic [NUM_SLOTS-1:0]                slot_full,
  output logic                                can_swap,
  output logic                                swap_empty,
  output logic [ROWS-1:0][BLOCK_W-1:0]        out_block,
  output logic                                swap_done,
  output logic                                need_new
);

  import tetris_pkg::*;

  localparam int unsigned SEL_W = $clog2(NUM_SLOTS);

  typedef logic [ROWS-1:0][BLOCK_W-1:0] block_t;

  block_t      slots [NUM_SLOTS];
  hold_state_t state;
  logic        hold_press;
  logic        cycle_press;
  logic        hold_accept;

  key_edge #(.KEY(HOLD_KEY)) u_hold_edge (
    .clk     (clk),
    .reset   (reset),
    .keycode (keycode),
    .press   (hold_press)
  );

  key_edge #(.KEY(CYCLE_KEY)) u_cycle_edge (
    .clk     (clk),
    .reset   (reset),
    .keycode (keycode),
    .press   (cycle_press)
  );

  // FALL and SPAWN are distinct codes, so requiring FALL here already gives
  // SPAWN priority over a same-cycle press.
  assign hold_accept = (state == HOLD_ARMED) && (game_state == GS_FALL) && hold_press;

  // Slot storage and occupancy flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
      slot_full <= '0;
    end else if (hold_accept) begin
      slots[slot_sel]     <= in_block;
      slot_full[slot_sel] <= 1'b1;
    end
  end

  // Hold FSM, returned piece, pulses and slot selection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HOLD_ARMED;
      out_block <= '0;
      swap_done <= 1'b0;
      need_new  <= 1'b0;
      slot_sel  <= '0;
    end else begin
      swap_done <= 1'b0;
      need_new  <= 1'b0;

      if (game_state == GS_SPAWN) begin
        state <= HOLD_ARMED;
      end else if (hold_accept) begin
        state <= HOLD_USED;
        if (slot_full[slot_sel]) begin
          out_block <= slots[slot_sel];
          swap_done <= 1'b1;
        end else begin
          need_new  <= 1'b1;
        end
      end

      if (cycle_press) slot_sel <= slot_sel + SEL_W'(1);
    end
  end

  assign sblock     = slots[slot_sel];
  assign can_swap   = (state == HOLD_ARMED);
  assign swap_empty = ~|slot_full;

endmodule

// File: doc/hold_bank.md
HOLD_BANK -- requirements
Module: hold_bank

Interface
REQ-001 The module SHALL declare parameter BLOCK_W, default 10, meaning bit width of one block row.
REQ-002 The module SHALL declare parameter ROWS, default 2, meaning rows per block pattern.
REQ-003 The module SHALL declare parameter NUM_SLOTS, default 4 (power of two, >=2), meaning number of hold slots.
REQ-004 The module SHALL declare parameters HOLD_KEY, default 8'h06, and CYCLE_KEY, default 8'h07, meaning the swap and slot-select keycodes.
REQ-005 Ports SHALL be:
- clk  in  1  system clock; one clock domain, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- keycode  in  8  current keyboard scancode, 8'h00 = no key
- game_state  in  3  game FSM state; SPAWN = 3'b010, FALL = 3'b100
- in_block  in  ROWS x BLOCK_W  active falling piece pattern
- slot_sel  out  log2(NUM_SLOTS)  currently selected slot index
- sblock  out  ROWS x BLOCK_W  contents of the selected slot
- slot_full  out  NUM_SLOTS  per-slot occupied flags
- can_swap  out  1  a hold is permitted in the current drop
- swap_empty  out  1  all slots empty
- out_block  out  ROWS x BLOCK_W  piece returned by the last swap
- swap_done  out  1  one-cycle pulse, a held piece was returned in out_block
- need_new  out  1  one-cycle pulse, piece stored into an empty slot; generator must spawn a fresh piece

Function
REQ-006 Keys SHALL act on press edges only: a press is keycode equal to the key value while the previous cycle's keycode differed; a held key SHALL produce exactly one press.
REQ-007 The hold FSM SHALL have states ARMED and USED; reset enters ARMED; can_swap SHALL be 1 exactly in ARMED.
REQ-008 In ARMED, with game_state == FALL and a HOLD_KEY press, the selected slot SHALL be written with in_block and the FSM SHALL enter USED at the same edge.
REQ-009 If the selected slot was empty at that edge, need_new SHALL pulse high for the following cycle, swap_done SHALL stay 0, and out_block SHALL hold its previous value.
REQ-010 If the selected slot was full, out_block SHALL take the slot's old contents, and swap_done SHALL pulse high for the following cycle, both registered (one-cycle latency from the press).
REQ-011 A HOLD_KEY press in USED, or in any game_state other than FALL, SHALL be ignored with no output change.
REQ-012 game_state == SPAWN SHALL force ARMED, leaving slot contents and flags unchanged; SPAWN SHALL take priority over any press in the same cycle.
REQ-013 A CYCLE_KEY press in any state SHALL increment slot_sel modulo NUM_SLOTS (NUM_SLOTS-1 wraps to 0); it SHALL NOT alter can_swap or slot contents.
REQ-014 slot_full[i] SHALL set when slot i is written and SHALL never clear except by reset; swap_empty SHALL equal NOR of slot_full.
REQ-015 sblock SHALL reflect the selected slot combinationally from registered slot storage and slot_sel.
REQ-016 swap_done and need_new SHALL never be high in the same cycle and SHALL each be high for exactly one cycle per accepted hold.

Reset
REQ-017 Asserting reset SHALL asynchronously clear all slots to zero, slot_full to 0, slot_sel to 0, out_block to 0, swap_done and need_new to 0, and set the FSM to ARMED (can_swap = 1, swap_empty = 1).
REQ-018 Reset asserted mid-hold SHALL cancel any pending pulse; the first press after deassertion SHALL be judged against the keycode sampled after reset, with the previous-keycode register reset to 8'h00.

Structure
REQ-019 Game state codes (SPAWN, FALL), default keycodes and BLOCK_W SHALL live in shared package tetris_pkg; hold_bank SHALL import them.
REQ-020 Press-edge detection SHALL be a sub-module key_edge (parameter KEY, input keycode, output press), instantiated once per key.

Verification
REQ-021 Reset, FALL, in_block = {10'h0F0,10'h00F}, HOLD_KEY press -> next cycle need_new = 1, slot_full = 4'b0001, sblock = {10'h0F0,10'h00F}, can_swap = 0.
REQ-022 Continuing, second HOLD_KEY press without SPAWN -> no pulses, contents unchanged; then SPAWN, FALL, in_block = {10'h3C0,10'h001}, press -> swap_done = 1, out_block = {10'h0F0,10'h00F}, sblock = {10'h3C0,10'h001}.
REQ-023 HOLD_KEY held steady for 20 cycles across a SPAWN -> exactly one accepted hold.
REQ-024 Four CYCLE_KEY presses from slot_sel = 0 -> slot_sel sequence 1,2,3,0; can_swap unchanged.
REQ-025 SPAWN and HOLD_KEY press in same cycle -> no write, can_swap = 1 after the edge.
REQ-026 Reset asserted one cycle after an accepted hold -> swap_done/need_new immediately 0, swap_empty = 1, slot_sel = 0.
